narrow_sink_arbiter: RTL and testbench

// - Shares one narrow result register (DST_W bits) among NREQ requesters, each driving a wider SRC_W-bit value.
// - Round-robin arbitration with a one-entry valid/ready output stage.
// - Narrowing is explicit saturation: when the source exceeds the sink range, the result is all ones.

---
 rtl/narrow_sink_arbiter.sv | 142 ++++++++++++++
 tb/tb_narrow_sink_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/narrow_sink_arbiter.sv
// Round-robin arbiter feeding one saturating narrow output register behind a valid/ready stage.
// Optional out_ovf/ovf_count ports are built when NARROW_OVF_FLAG_EN is defined.
module narrow_sink_arbiter #(
    parameter  int unsigned NREQ  = 4,
    parameter  int unsigned SRC_W = 4,
    parameter  int unsigned DST_W = 3,
    localparam int unsigned IDX_W = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*SRC_W-1:0] data,
    output logic [NREQ-1:0]       gnt,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DST_W-1:0]      out_data,
    output logic [IDX_W-1:0]      out_src
`ifdef NARROW_OVF_FLAG_EN
    ,
    output logic                  out_ovf,
    output logic [7:0]            ovf_count
`endif
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [DST_W-1:0] out_data_q, out_data_d;
    logic [IDX_W-1:0] out_src_q, out_src_d;

    logic             can_load_c;
    logic             grant_c;
    logic [IDX_W-1:0] gnt_idx_c;
    logic [SRC_W-1:0] gnt_word_c;
    logic             sat_c;
    logic [DST_W-1:0] narrow_c;

    // First requester at or after rr_ptr, wrapping; gated by load capacity and reset
    always_comb begin
        logic [IDX_W:0] cand;
        cand       = '0;
        gnt        = '0;
        grant_c    = 1'b0;
        gnt_idx_c  = '0;
        can_load_c = (state_q == ST_EMPTY) || out_ready;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(NREQ)) begin
                cand = cand - (IDX_W+1)'(NREQ);
            end
            if (rst_n && can_load_c && !grant_c && req[cand[IDX_W-1:0]]) begin
                grant_c   = 1'b1;
                gnt_idx_c = cand[IDX_W-1:0];
            end
        end
        if (grant_c) begin
            gnt[gnt_idx_c] = 1'b1;
        end
    end

    // Saturate rather than drop source MSBs
    always_comb begin
        gnt_word_c = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (gnt[k]) begin
                gnt_word_c = data[k*SRC_W +: SRC_W];
            end
        end
        sat_c    = (gnt_word_c[SRC_W-1:DST_W] != '0);
        narrow_c = sat_c ? '1 : gnt_word_c[DST_W-1:0];
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        out_data_d = out_data_q;
        out_src_d  = out_src_q;
        case (state_q)
            ST_EMPTY: if (grant_c) state_d = ST_FULL;
            ST_FULL:  if (out_ready && !grant_c) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
        if (grant_c) begin
            out_data_d = narrow_c;
            out_src_d  = gnt_idx_c;
            rr_ptr_d   = (gnt_idx_c == IDX_W'(NREQ-1)) ? '0 : gnt_idx_c + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            rr_ptr_q   <= '0;
            out_data_q <= '0;
            out_src_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            out_data_q <= out_data_d;
            out_src_q  <= out_src_d;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

`ifdef NARROW_OVF_FLAG_EN
    logic       out_ovf_q, out_ovf_d;
    logic [7:0] ovf_count_q, ovf_count_d;

    // Flag follows the data word; the event count sticks at its maximum
    always_comb begin
        out_ovf_d   = out_ovf_q;
        ovf_count_d = ovf_count_q;
        if (grant_c) begin
            out_ovf_d = sat_c;
            if (sat_c && (ovf_count_q != 8'hFF)) begin
                ovf_count_d = ovf_count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_ovf_q   <= 1'b0;
            ovf_count_q <= '0;
        end else begin
            out_ovf_q   <= out_ovf_d;
            ovf_count_q <= ovf_count_d;
        end
    end

    assign out_ovf   = out_ovf_q;
    assign ovf_count = ovf_count_q;
`endif

endmodule

// File: tb/tb_narrow_sink_arbiter.sv
// Bench for narrow_sink_arbiter (NREQ=4, SRC_W=4, DST_W=3): vector table plus reset/saturation sequences.
module tb_narrow_sink_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] data;
    logic [3:0]  gnt;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_data;
    logic [1:0]  out_src;
`ifdef NARROW_OVF_FLAG_EN
    logic        out_ovf;
    logic [7:0]  ovf_count;
`endif

    narrow_sink_arbiter #(.NREQ(4), .SRC_W(4), .DST_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data      (data),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src)
`ifdef NARROW_OVF_FLAG_EN
        ,
        .out_ovf   (out_ovf),
        .ovf_count (ovf_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [15:0] data;
        logic        rdy;
        logic [3:0]  gnt;
        string       name;
    } vec_t;

    typedef struct {
        logic [2:0] d;
        logic [1:0] src;
        logic       ovf;
    } exp_t;

    localparam int NV = 13;
    vec_t tv[NV];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic mvalid = 1'b0;
    int   mcnt = 0;

    function automatic logic [2:0] narrow3(input logic [3:0] w);
        return (w > 4'd7) ? 3'd7 : w[2:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One cycle: drive at negedge, check just after, update the model, then let the edge happen
    task automatic step(input logic [3:0] r, input logic [15:0] d, input logic rdy,
                        input logic [3:0] eg, input string nm);
        exp_t        e;
        int          k;
        logic [3:0]  w;
        @(negedge clk);
        req       = r;
        data      = d;
        out_ready = rdy;
        #1;
        chk({nm, ":gnt"}, 32'(gnt), 32'(eg));
        chk({nm, ":valid"}, 32'(out_valid), 32'(mvalid));
`ifdef NARROW_OVF_FLAG_EN
        chk({nm, ":ovf_count"}, 32'(ovf_count), 32'(mcnt));
`endif
        if (mvalid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s:sb_empty got out_valid=1 expected no pending word", nm);
            end else begin
                chk({nm, ":data"}, 32'(out_data), 32'(sb[0].d));
                chk({nm, ":src"}, 32'(out_src), 32'(sb[0].src));
`ifdef NARROW_OVF_FLAG_EN
                chk({nm, ":ovf"}, 32'(out_ovf), 32'(sb[0].ovf));
`endif
                if (rdy) void'(sb.pop_front());
            end
        end
        if (eg != 4'b0000) begin
            k = 0;
            for (int i = 0; i < 4; i++) if (eg[i]) k = i;
            w     = d[k*4 +: 4];
            e.d   = narrow3(w);
            e.src = 2'(k);
            e.ovf = (w > 4'd7);
            sb.push_back(e);
            mvalid = 1'b1;
            if (e.ovf && mcnt != 255) mcnt++;
        end else if (rdy) begin
            mvalid = 1'b0;
        end
        @(posedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0]  = '{4'b0001, 16'h0005, 1'b1, 4'b0001, "load0"};
        tv[1]  = '{4'b0100, 16'h0C00, 1'b1, 4'b0100, "sat2"};
        tv[2]  = '{4'b1000, 16'h8000, 1'b1, 4'b1000, "load3"};
        tv[3]  = '{4'b1111, 16'h2791, 1'b1, 4'b0001, "rot0"};
        tv[4]  = '{4'b1111, 16'h2791, 1'b1, 4'b0010, "rot1"};
        tv[5]  = '{4'b1111, 16'h2791, 1'b1, 4'b0100, "rot2"};
        tv[6]  = '{4'b1111, 16'h2791, 1'b1, 4'b1000, "rot3"};
        tv[7]  = '{4'b1111, 16'h2791, 1'b1, 4'b0001, "rot_wrap"};
        tv[8]  = '{4'b0000, 16'h0000, 1'b0, 4'b0000, "hold"};
        tv[9]  = '{4'b0010, 16'h0030, 1'b0, 4'b0000, "hold_req"};
        tv[10] = '{4'b0010, 16'h0030, 1'b1, 4'b0010, "reload"};
        tv[11] = '{4'b0000, 16'h0000, 1'b1, 4'b0000, "drain"};
        tv[12] = '{4'b0000, 16'h0000, 1'b0, 4'b0000, "idle"};

        rst_n     = 1'b0;
        req       = 4'b1111;
        data      = 16'h0000;
        out_ready = 1'b0;
        #2;
        chk("rst:gnt", 32'(gnt), 32'd0);
        chk("rst:valid", 32'(out_valid), 32'd0);
        chk("rst:data", 32'(out_data), 32'd0);
        chk("rst:src", 32'(out_src), 32'd0);
`ifdef NARROW_OVF_FLAG_EN
        chk("rst:ovf", 32'(out_ovf), 32'd0);
        chk("rst:ovf_count", 32'(ovf_count), 32'd0);
`endif
        @(negedge clk);
        req   = 4'b0000;
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            step(tv[i].req, tv[i].data, tv[i].rdy, tv[i].gnt, tv[i].name);
        end

        // Reset while a word is pending: valid drops with no edge, pointer returns to 0
        step(4'b0100, 16'h0200, 1'b0, 4'b0100, "pre_rst_load");
        step(4'b0100, 16'h0200, 1'b0, 4'b0000, "pre_rst_hold");
        @(negedge clk);
        req = 4'b1111;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst:valid", 32'(out_valid), 32'd0);
        chk("midrst:gnt", 32'(gnt), 32'd0);
        chk("midrst:data", 32'(out_data), 32'd0);
        chk("midrst:src", 32'(out_src), 32'd0);
        sb.delete();
        mvalid = 1'b0;
        mcnt   = 0;
        req    = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b1010, 16'hB040, 1'b1, 4'b0010, "post_rst");
        step(4'b0000, 16'h0000, 1'b1, 4'b0000, "post_rst_drain");

`ifdef NARROW_OVF_FLAG_EN
        for (int i = 0; i < 258; i++) begin
            step(4'b0001, 16'h000F, 1'b1, 4'b0001, "sat_run");
        end
        step(4'b0000, 16'h0000, 1'b1, 4'b0000, "sat_drain");
        #1;
        chk("ovf_stick", 32'(ovf_count), 32'd255);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
